// File: rtl/rv_stall_fifo.sv
// rv_stall_fifo: bounded valid/ready FIFO with occupancy count, synchronous
// flush and optional LFSR-driven pseudo-random back-pressure on both sides.
// Storage is a circular buffer. The pointers wrap explicitly at DEPTH-1, so
// DEPTH does not have to be a power of two. Handshake outputs are
// combinational masks of registered state, so no transfer can complete while
// rst_n or flush is asserted.

module rv_stall_fifo #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [7:0]  STALL_THR = 8'd64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_en,
  input  logic                       flush,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Circular-buffer pointer advance with explicit wrap (non-power-of-2 safe).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PTR_LAST) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1'b1);
    end
    return r;
  endfunction

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11 (shift toward MSB).
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              in_stall_q, in_stall_d;
  logic              out_stall_q, out_stall_d;

  logic not_full_s;
  logic not_empty_s;
  logic push_s;
  logic pop_s;

  // Handshake masks: reset and flush block both sides; stalls gate each side.
  always_comb begin
    not_full_s  = (count_q < DEPTH_C);
    not_empty_s = (count_q != {CW{1'b0}});
    in_rdy      = rst_n & ~flush & not_full_s  & ~in_stall_q;
    out_vld     = rst_n & ~flush & not_empty_s & ~out_stall_q;
    push_s      = in_vld & in_rdy;
    pop_s       = out_vld & out_rdy;
  end

  // Read data is forced to zero whenever nothing valid is presented.
  always_comb begin
    if (out_vld) begin
      out_data = mem_q[rd_ptr_q];
    end else begin
      out_data = {DATA_W{1'b0}};
    end
  end

  assign count = count_q;

  // Next-state for pointers and occupancy; flush clears them, overriding traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state for the stall generator; it runs only while stall_en is high.
  always_comb begin
    lfsr_d      = lfsr_q;
    in_stall_d  = stall_en & (lfsr_q[7:0]  < STALL_THR);
    out_stall_d = stall_en & (lfsr_q[15:8] < STALL_THR);
    if (stall_en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      lfsr_q      <= SEED;
      in_stall_q  <= 1'b0;
      out_stall_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lfsr_q      <= lfsr_d;
      in_stall_q  <= in_stall_d;
      out_stall_q <= out_stall_d;
    end
  end

  // Storage write; only a completed push updates an entry.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  rv_stall_fifo_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_i  (count_q),
    .wr_ptr_i (wr_ptr_q),
    .rd_ptr_i (rd_ptr_q)
  );

endmodule

// rv_stall_fifo_chk: occupancy and pointer range properties for rv_stall_fifo.
module rv_stall_fifo_chk #(
  parameter int unsigned DEPTH = 8
) (
  input logic                       clk,
  input logic                       rst_n,
  input logic [$clog2(DEPTH+1)-1:0] count_i,
  input logic [$clog2(DEPTH)-1:0]   wr_ptr_i,
  input logic [$clog2(DEPTH)-1:0]   rd_ptr_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count_i <= DEPTH_C);
  a_wr_ptr_bound : assert property (@(posedge clk) disable iff (!rst_n) wr_ptr_i <= PTR_LAST);
  a_rd_ptr_bound : assert property (@(posedge clk) disable iff (!rst_n) rd_ptr_i <= PTR_LAST);

endmodule

// File: tb/tb_rv_stall_fifo.sv
// tb_rv_stall_fifo: directed and seeded-random stimulus for rv_stall_fifo.
// A queue-based reference model predicts every output on every cycle.
// Hand-computed literal checks pin the model, including the first LFSR stall.
`timescale 1ns/1ps

module tb_rv_stall_fifo;

  localparam int          DEPTH   = 8;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [7:0]  THR     = 8'd64;
  localparam int          N_WORDS = 1000;
  localparam int          MAX_CYC = 4000;

  logic        clk = 1'b0;
  logic        rst_n, stall_en, flush, in_vld, out_rdy;
  logic        in_rdy, out_vld;
  logic [31:0] in_data, out_data;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  rv_stall_fifo #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .SEED      (SEED),
    .STALL_THR (THR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_en (stall_en),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [15:0] m_lfsr;
  bit          m_in_stall, m_out_stall;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic bit e_in_rdy();
    return rst_n && !flush && (mq.size() < DEPTH) && !m_in_stall;
  endfunction

  function automatic bit e_out_vld();
    return rst_n && !flush && (mq.size() != 0) && !m_out_stall;
  endfunction

  function automatic logic [31:0] e_out_data();
    if (e_out_vld()) return mq[0];
    return 32'd0;
  endfunction

  // Advance the model on each rising edge from the inputs held before it.
  always @(posedge clk) begin : model_upd
    bit p, q;
    p = in_vld && e_in_rdy();
    q = e_out_vld() && out_rdy;
    if (!rst_n) begin
      mq.delete();
      m_lfsr      = SEED;
      m_in_stall  = 1'b0;
      m_out_stall = 1'b0;
    end else begin
      if (flush) mq.delete();
      else begin
        if (q) void'(mq.pop_front());
        if (p) mq.push_back(in_data);
      end
      m_in_stall  = stall_en && (m_lfsr[7:0]  < THR);
      m_out_stall = stall_en && (m_lfsr[15:8] < THR);
      if (stall_en) m_lfsr = lfsr_next(m_lfsr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_rdy",   {31'd0, in_rdy},  {31'd0, e_in_rdy()});
      chk("m_out_vld",  {31'd0, out_vld}, {31'd0, e_out_vld()});
      chk("m_out_data", out_data,         e_out_data());
      chk("m_count",    {28'd0, count},   mq.size());
    end
  end

  // ---------------- stimulus ----------------
  bit          vld_a [MAX_CYC];
  bit          rdy_a [MAX_CYC];
  logic [31:0] data_a[N_WORDS];
  logic [1:0]  tr_a  [MAX_CYC];
  bit          saw_in_stall, saw_out_stall;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_en = 1'b0; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    out_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_vld = 1'b1; in_data = base + i;
      step();
    end
    in_vld = 1'b0;
  endtask

  // Random traffic with stalls; record=1 stores the handshake trace, record=0 compares to it.
  task automatic run_random(input bit record, output int ncyc, output int mism);
    int widx, ridx, c, d;
    widx = 0; ridx = 0; c = 0; mism = 0;
    stall_en = 1'b1;
    while (widx < N_WORDS && c < MAX_CYC) begin
      in_vld = vld_a[c]; in_data = data_a[widx]; out_rdy = rdy_a[c];
      #2;
      if (c == 3) chk("lfsr_pin_c3_in_rdy", {31'd0, in_rdy}, 32'd1);
      if (c == 4) chk("lfsr_pin_c4_in_rdy", {31'd0, in_rdy}, 32'd0);
      if (!in_rdy && count < 4'd8) saw_in_stall = 1'b1;
      if (!out_vld && count != 4'd0) saw_out_stall = 1'b1;
      if (out_vld && out_rdy) begin
        chk("sb_order", out_data, data_a[ridx]);
        ridx++;
      end
      if (record) tr_a[c] = {in_rdy, out_vld};
      else if (tr_a[c] !== {in_rdy, out_vld}) mism++;
      if (in_vld && in_rdy) widx++;
      step();
      c++;
    end
    chk("words_pushed", widx, N_WORDS);
    ncyc = c;
    in_vld = 1'b0; out_rdy = 1'b1;
    d = 0;
    while (ridx < N_WORDS && d < MAX_CYC) begin
      #2;
      if (out_vld && out_rdy) begin
        chk("sb_order", out_data, data_a[ridx]);
        ridx++;
      end
      step();
      d++;
    end
    chk("words_popped", ridx, N_WORDS);
    out_rdy = 1'b0; stall_en = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ncyc_a, ncyc_b, mism_a, mism_b;
    rst_n = 1'b0; stall_en = 1'b0; flush = 1'b0;
    in_vld = 1'b0; out_rdy = 1'b0; in_data = 32'd0;

    // 1: reset held for three cycles
    step();
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    #2;
    chk("rst_in_rdy",   {31'd0, in_rdy},  32'd1);
    chk("rst_out_vld",  {31'd0, out_vld}, 32'd0);
    chk("rst_count",    {28'd0, count},   32'd0);
    chk("rst_out_data", out_data,         32'd0);
    step();

    // 2: fill to full, then drain in order
    push_n(8, 32'd1);
    in_vld = 1'b1; in_data = 32'd9;
    #2;
    chk("full_count",  {28'd0, count},  32'd8);
    chk("full_in_rdy", {31'd0, in_rdy}, 32'd0);
    step();
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #2;
      chk("drain_data", out_data, i);
      chk("drain_vld",  {31'd0, out_vld}, 32'd1);
      step();
    end
    out_rdy = 1'b0;
    #2;
    chk("empty_count", {28'd0, count}, 32'd0);
    step();

    // 3: full with push+pop requested -> pop only; then simultaneous push and pop
    push_n(8, 32'd11);
    in_vld = 1'b1; in_data = 32'd19; out_rdy = 1'b1;
    #2;
    chk("fs_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("fs_data0",  out_data, 32'd11);
    step();
    #2;
    chk("fs_count7a", {28'd0, count}, 32'd7);
    chk("fs_data1",   out_data, 32'd12);
    step();
    in_vld = 1'b0;
    #2;
    chk("fs_count7b", {28'd0, count}, 32'd7);
    chk("fs_data2",   out_data, 32'd13);
    repeat (7) step();
    out_rdy = 1'b0;
    #2;
    chk("fs_empty", {28'd0, count}, 32'd0);
    step();

    // 4: flush overrides traffic
    push_n(5, 32'd21);
    flush = 1'b1; in_vld = 1'b1; in_data = 32'd26; out_rdy = 1'b1;
    #2;
    chk("fl_in_rdy",  {31'd0, in_rdy},  32'd0);
    chk("fl_out_vld", {31'd0, out_vld}, 32'd0);
    chk("fl_count5",  {28'd0, count},   32'd5);
    step();
    flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    #2;
    chk("fl_count0",   {28'd0, count},   32'd0);
    chk("fl_out_vld2", {31'd0, out_vld}, 32'd0);
    step();

    // 6: reset mid-traffic discards contents
    push_n(4, 32'd31);
    #2;
    chk("mr_count4", {28'd0, count}, 32'd4);
    rst_n = 1'b0;
    step();
    #2;
    chk("mr_count0",  {28'd0, count},   32'd0);
    chk("mr_in_rdy",  {31'd0, in_rdy},  32'd0);
    chk("mr_out_vld", {31'd0, out_vld}, 32'd0);
    rst_n = 1'b1;
    in_vld = 1'b1; in_data = 32'd40;
    step();
    in_vld = 1'b0; out_rdy = 1'b1;
    #2;
    chk("mr_first", out_data, 32'd40);
    chk("mr_count1", {28'd0, count}, 32'd1);
    step();
    out_rdy = 1'b0;

    // 5: seeded random stalls, run twice from the same seed
    for (int i = 0; i < MAX_CYC; i++) begin
      vld_a[i] = ($urandom_range(0, 3) != 0);
      rdy_a[i] = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < N_WORDS; i++) data_a[i] = $urandom;
    saw_in_stall = 1'b0; saw_out_stall = 1'b0;
    do_reset();
    run_random(1'b1, ncyc_a, mism_a);
    chk("saw_in_stall",  {31'd0, saw_in_stall},  32'd1);
    chk("saw_out_stall", {31'd0, saw_out_stall}, 32'd1);
    do_reset();
    run_random(1'b0, ncyc_b, mism_b);
    chk("trace_len",    ncyc_b, ncyc_a);
    chk("trace_repeat", mism_b, 32'd0);

    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
